// File: rtl/accum5_issue.sv
// accum5_issue: operation issue stage in front of the 4-bit accumulator/ALU.
// Buffers host requests in a small FIFO, rejects illegal mode codes, drives
// one operation at a time onto the ALU inputs, waits LAT edges, then captures
// the ALU result and offers it on a valid/ready output.
//
// Ports:
//   Clk, nReset            clock, asynchronous active-low reset
//   in_valid/in_ready      host request handshake (in_ready = FIFO not full)
//   in_a, in_b, in_m, in_cin  request operands, mode code, carry-in
//   alu_a, alu_b, alu_m, alu_cin  registered drive to the ALU
//   alu_r, alu_of          ALU result and flag
//   out_valid/out_ready    result handshake; out_r, out_of captured result
//   level                  FIFO occupancy
//   ill_cnt                saturating count of rejected illegal-mode pushes
module accum5_issue #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [3:0]   in_m,
  input  logic         in_cin,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_m,
  output logic         alu_cin,
  input  logic [W-1:0] alu_r,
  input  logic         alu_of,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic         out_of,
  output logic [3:0]   level,
  output logic [7:0]   ill_cnt
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW    = 2 * W + 5;
  localparam logic [3:0]  M_MAX = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t        state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    cnt, cnt_next;
  logic          push, illegal, pop, capture, retire;

  logic [W-1:0]  head_a, head_b;
  logic [3:0]    head_m;
  logic          head_cin;

  // Full check uses registered occupancy only; a same-cycle pop does not help.
  assign in_ready = (level != 4'(DEPTH));
  assign push     = in_valid & in_ready & (in_m <= M_MAX);
  assign illegal  = in_valid & in_ready & (in_m > M_MAX);

  assign {head_a, head_b, head_m, head_cin} = mem[rd_ptr];

  // State register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state, pop and capture decisions
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (level != 4'd0) begin
          pop        = 1'b1;
          cnt_next   = 3'(LAT);
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 3'd1;
        if (cnt == 3'd1) begin
          capture    = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          retire = 1'b1;
          if (level != 4'd0) begin
            pop        = 1'b1;
            cnt_next   = 3'(LAT);
            state_next = S_WAIT;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO storage; flushed logically by the pointer/level reset
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b, in_m, in_cin};
  end

  // Pointers, occupancy, ALU drive, result capture, illegal counter
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_m     <= '0;
      alu_cin   <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_of    <= 1'b0;
      ill_cnt   <= '0;
    end else begin
      cnt   <= cnt_next;
      level <= level + 4'(push) - 4'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        alu_a   <= head_a;
        alu_b   <= head_b;
        alu_m   <= head_m;
        alu_cin <= head_cin;
      end
      if (capture) begin
        out_r     <= alu_r;
        out_of    <= alu_of;
        out_valid <= 1'b1;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      if (illegal && (ill_cnt != 8'hFF)) ill_cnt <= ill_cnt + 8'd1;
    end
  end

endmodule

// File: doc/accum5_issue.md
# accum5_issue

Operation issue stage sitting directly upstream of the 4-bit accumulator/ALU (`accum5`). It buffers operation requests from a host in a small FIFO, screens out illegal mode codes, and drives one operation at a time onto the ALU's `a`/`b`/`cin`/`m` inputs. After a fixed, parameterised latency it captures the ALU's `r`/`of` and presents the result through a valid/ready handshake.

## Interface

- `W`, 4: operand and result width; must match the ALU.
- `DEPTH`, 4: FIFO entries; power of two, 2..8.
- `LAT`, 1: clock edges from ALU-input update to result sample; legal range 1..7.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host request valid.
- `in_ready`  out  1  FIFO not full.
- `in_a`, `in_b`  in  W  operands.
- `in_m`  in  4  mode code: 0 add, 1 sub, 2 compare, 3 and, 4 or, 5 complement.
- `in_cin`  in  1  carry-in.
- `alu_a`, `alu_b`  out  W  registered drive to ALU `a`, `b`.
- `alu_m`  out  4  registered drive to ALU `m`.
- `alu_cin`  out  1  registered drive to ALU `cin`.
- `alu_r`  in  W  ALU result `r`.
- `alu_of`  in  1  ALU flag `of`.
- `out_valid`  out  1  captured result valid.
- `out_ready`  in  1  consumer ready.
- `out_r`  out  W  captured result.
- `out_of`  out  1  captured flag.
- `level`  out  4  FIFO occupancy, 0..DEPTH.
- `ill_cnt`  out  8  count of rejected illegal-mode pushes; saturates at 255.

## Operation

- **Push.** A push is accepted on an edge where `in_valid & in_ready` and `in_m <= 5`. The entry {a, b, m, cin} is written at the tail.
  - `in_m >= 6`: the entry is not written and `ill_cnt` increments if below 255. `in_ready` is unaffected.
- **`in_ready`** is `level != DEPTH`. It is based on occupancy only: a pop in the same cycle does not free a slot for a push while full.
- **FSM states** (encoding is free):
  - **IDLE**: FIFO empty or no operation in flight. If `level != 0`, pop the head: `alu_*` load the head entry at this edge and the counter is set to LAT. Go to WAIT.
  - **WAIT**: the counter decrements each edge. On the edge where the counter goes 1→0, register `alu_r` into `out_r` and `alu_of` into `out_of`, set `out_valid`, and go to HOLD.
  - **HOLD**: `out_valid=1`; `out_r`/`out_of` are stable. On an edge with `out_ready=1`:
    - FIFO non-empty: clear `out_valid`, pop the next entry onto `alu_*` at the same edge, and go to WAIT.
    - FIFO empty: clear `out_valid` and go to IDLE.
- **`alu_*` hold.** `alu_*` keep their last issued value in every state and change only on a pop.
- **No bypass.** A push into an empty FIFO while IDLE is popped on the following edge, not the push edge.
- **Simultaneous push and pop.** Both take effect and `level` is unchanged. Pointers wrap modulo DEPTH.
- **Widths.** Operands pass through unmodified. This block performs no arithmetic on the data.
- **Reset.** Asserting `nReset` low at any time aborts the in-flight operation, flushes the FIFO, and drops any pending result.

## Timing

- **Reset values:** `alu_a`, `alu_b`, `alu_m` = 0; `alu_cin` = 0; `out_valid` = 0; `out_r` = 0; `out_of` = 0; `level` = 0; `ill_cnt` = 0; `in_ready` = 1; state IDLE.
- **Latency.** Push at edge T → pop onto `alu_*` at T+1 → `out_valid` rises at T+1+LAT.
- **Throughput.** One operation per LAT+1 edges when `out_ready` is held high.
- **Handshakes.** `out_r`, `out_of`, and `out_valid` are registered outputs. `in_ready` and `level` reflect registered occupancy.
- **Reset release.** The first push is accepted on the first edge after `nReset` rises.

## Test plan

- **Reset and single add.** Reset, then push a=1010, b=0101, m=0000, cin=0 with LAT=1 and an ALU model. Required: `alu_a=1010` one edge after the push; `out_valid` two edges after the push with `out_r=1111`, `out_of=0`; `ill_cnt=0`.
- **Back-to-back stream.** Push the sequence add 1111+0001, sub 1111−1001, and 1001&0001, or 1010|0101, complement 0111 with `out_ready=1`. Required: results 0000/of=1, 0110, 0001, 1111, 1000 in order, spaced LAT+1 edges apart.
- **Illegal mode.** Push m=0110 and m=1111. Required: `level` stays 0, `ill_cnt=2`, no ALU activity. Then push 256 illegal pushes in total: `ill_cnt` holds at 255.
- **Full FIFO with consumer stalled.** Hold `out_ready=0` and push 6 operations (DEPTH=4). Required: `in_ready=0` once `level=4`, and the extra pushes are not accepted. Release `out_ready`: all accepted results emerge in order and `level` returns to 0.
- **Backpressure stability.** Hold `out_ready=0` for 10 cycles in HOLD. Required: `out_r`, `out_of`, and `alu_*` remain stable and no pop occurs.
- **Reset mid-operation.** Assert `nReset` during WAIT with 3 entries queued. Required: every output returns to its reset value asynchronously; after release, no stale result appears and `level=0`.
